id_ibuf: RTL



---
 rtl/id_ibuf_if.sv | 38 +++
 rtl/id_ibuf.sv | 131 +++++++++++++
 2 files changed

// File: rtl/id_ibuf_if.sv
// id_ibuf_if -- IF->ID instruction buffer bus.
//   Groups the fetch-side push signals, the decode-side head/control signals
//   and the occupancy count of id_ibuf.
//   slave  : the buffer (receives IF entries and ID control, drives head/count)
//   master : the surrounding pipeline (drives IF entries and ID control)
//   DEPTH must match the DEPTH of the id_ibuf it connects to (count width).
interface id_ibuf_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_if_i;
    logic [31:0]   instr_if_i;
    logic          is_compressed_if_i;
    logic          valid_if_i;
    logic          ready_if_o;
    logic          stall_id_i;
    logic          flush_id_i;
    logic [31:0]   pc_id_o;
    logic [31:0]   instr_id_o;
    logic          is_compressed_id_o;
    logic          valid_id_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  pc_if_i, instr_if_i, is_compressed_if_i, valid_if_i,
        input  stall_id_i, flush_id_i,
        output ready_if_o, pc_id_o, instr_id_o, is_compressed_id_o,
        output valid_id_o, count_o
    );

    modport master (
        output pc_if_i, instr_if_i, is_compressed_if_i, valid_if_i,
        output stall_id_i, flush_id_i,
        input  ready_if_o, pc_id_o, instr_id_o, is_compressed_id_o,
        input  valid_id_o, count_o
    );
endinterface

// File: rtl/id_ibuf.sv
// id_ibuf -- instruction buffer between fetch (IF) and decode (ID).
//   Circular FIFO of DEPTH {pc, instr, is_compressed} entries. The head entry
//   is presented combinationally to ID; ID pops it unless stalled or flushing.
//   A full buffer still accepts when the head is popped in the same cycle.
//   Flush empties the buffer and discards any push in that cycle.
// Ports:
//   clk_i  clock (rising edge)
//   rst_i  asynchronous active-high reset
//   bus    id_ibuf_if.slave: pc/instr/is_compressed/valid_if_i, ready_if_o,
//          stall_id_i, flush_id_i, pc/instr/is_compressed/valid_id_o, count_o
// Parameters:
//   DEPTH  entries, power of two 2..16
//   ISA_C  1: keep the compressed flag, 0: flag forced to 0
// Build option:
//   ID_IBUF_BYPASS_EN  when defined, an empty buffer forwards the IF entry to
//                      ID in the same cycle; otherwise push-to-head is 1 cycle.
module id_ibuf #(
    parameter int DEPTH = 4,
    parameter int ISA_C = 0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    id_ibuf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   last_pc_q, last_pc_d;

    entry_t in_e, head_e;
    logic   empty, byp, valid_id, pop, ready, push, wr_en, rd_adv;

    always_comb begin
        in_e.pc    = bus.pc_if_i;
        in_e.instr = bus.instr_if_i;
        in_e.c     = (ISA_C != 0) ? bus.is_compressed_if_i : 1'b0;
    end

    assign empty = (cnt_q == '0);

`ifdef ID_IBUF_BYPASS_EN
    // Forward the incoming entry straight to ID while the buffer is empty.
    // Gated by rst_i so reset values show immediately even with IF valid.
    assign byp = empty && bus.valid_if_i && !bus.flush_id_i && !rst_i;
`else
    assign byp = 1'b0;
`endif

    assign valid_id = !empty || byp;
    assign pop      = valid_id && !bus.stall_id_i && !bus.flush_id_i;
    assign ready    = bus.flush_id_i || (cnt_q < CW'(DEPTH)) || pop;
    assign push     = bus.valid_if_i && ready && !bus.flush_id_i;
    // A bypassed entry that ID takes immediately never touches storage.
    assign wr_en    = push && !(byp && pop);
    assign rd_adv   = pop && !byp;

    always_comb begin
        head_e = mem_q[rd_q];
        if (empty) begin
            if (byp) begin
                head_e = in_e;
            end else begin
                head_e.pc    = last_pc_q;
                head_e.instr = NOP;
                head_e.c     = 1'b0;
            end
        end
    end

    assign bus.ready_if_o         = ready;
    assign bus.valid_id_o         = valid_id;
    assign bus.pc_id_o            = head_e.pc;
    assign bus.instr_id_o         = head_e.instr;
    assign bus.is_compressed_id_o = head_e.c;
    assign bus.count_o            = cnt_q;

    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        last_pc_d = last_pc_q;
        if (bus.flush_id_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en)
                wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            if (rd_adv)
                rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
            if (pop)
                last_pc_d = head_e.pc;
            case ({wr_en, rd_adv})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            last_pc_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_en && !bus.flush_id_i)
            mem_q[wr_q] <= in_e;
    end
endmodule
